// File: rtl/dmux8way16_stream.sv
// -----------------------------------------------------------------------------
// dmux8way16_stream
//
// Purpose:
//   Routes a valid/ready input stream into one of eight output channels.
//   Each output channel owns a small FIFO of DEPTH entries.
//   A word pushed at rising edge N becomes visible on its channel after edge N.
//   There is no same-cycle bypass and no full-bypass path.
//
// Handshake semantics (all ports):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   Ready never depends on valid.
//   in_ready   = NOT full[in_sel] (or NOT any-full for a broadcast).
//   out_valid[k] = channel k FIFO is non-empty.
//   A pop of channel k happens when out_valid[k] && out_ready[k].
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     upstream word present
//   in_ready     block accepts the word this cycle
//   in_data      word to route (WIDTH bits)
//   in_sel       destination channel 0..7
//   in_bcast     (only with DMUX8WAY16_BCAST_EN) write the word to all channels
//   out_valid    per-channel "head word present"
//   out_ready    per-channel consumer ready
//   out_data     channel k head word at [k*WIDTH +: WIDTH]; zero while empty
//   accept_cnt   number of accepted words since reset, wraps at 16 bits
//
// Configuration macro:
//   DMUX8WAY16_BCAST_EN  adds the in_bcast port and the broadcast push.
//                        When it is undefined, the block behaves as if in_bcast
//                        were tied to 0.
// -----------------------------------------------------------------------------
module dmux8way16_stream #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         in_sel,
`ifdef DMUX8WAY16_BCAST_EN
  input  logic               in_bcast,
`endif
  output logic [7:0]         out_valid,
  input  logic [7:0]         out_ready,
  output logic [8*WIDTH-1:0] out_data,
  output logic [15:0]        accept_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic       w_bcast;
  logic [7:0] w_full;
  logic       w_accept;
  logic [15:0] r_accept_cnt;

`ifdef DMUX8WAY16_BCAST_EN
  assign w_bcast = in_bcast;
`else
  assign w_bcast = 1'b0;
`endif

  // A broadcast needs room in every channel, so any full channel stalls it.
  assign in_ready   = w_bcast ? ~(|w_full) : ~w_full[in_sel];
  assign w_accept   = in_valid & in_ready;
  assign accept_cnt = r_accept_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_accept_cnt <= 16'h0000;
    end else if (w_accept) begin
      r_accept_cnt <= r_accept_cnt + 16'h0001;
    end
  end

  genvar k;
  generate
    for (k = 0; k < 8; k++) begin : g_ch
      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [AW-1:0]    r_wr_ptr;
      logic [AW-1:0]    r_rd_ptr;
      logic [CW-1:0]    r_count;
      logic             w_push;
      logic             w_pop;

      assign w_full[k]    = (r_count == FULL_CNT);
      assign out_valid[k] = (r_count != '0);
      assign w_push       = w_accept & (w_bcast | (in_sel == 3'(k)));
      assign w_pop        = out_valid[k] & out_ready[k];

      // Storage is not reset; the head is gated by occupancy so stale words
      // from before a reset are never visible.
      assign out_data[k*WIDTH +: WIDTH] = out_valid[k] ? r_mem[r_rd_ptr] : '0;

      always_ff @(posedge clk) begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= in_data;
        end
      end

      // Pointers wrap naturally because DEPTH is a power of two.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
          end
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
          end
          case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_dmux8way16_stream.sv
// -----------------------------------------------------------------------------
// tb_dmux8way16_stream
//
// Directed bench for dmux8way16_stream (WIDTH=16, DEPTH=2).
// Inputs change just after the falling edge.
// Outputs are sampled at the falling edge, or 1 time unit after an input
// change for the combinational in_ready.
// -----------------------------------------------------------------------------
module tb_dmux8way16_stream;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_data;
  logic [2:0]   in_sel;
`ifdef DMUX8WAY16_BCAST_EN
  logic         in_bcast;
`endif
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [127:0] out_data;
  logic [15:0]  accept_cnt;

  int n_tests;
  int n_fail;

  dmux8way16_stream #(.WIDTH(16), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
`ifdef DMUX8WAY16_BCAST_EN
    .in_bcast   (in_bcast),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .accept_cnt (accept_cnt)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- helpers
  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lane(input int k);
    return out_data[k*16 +: 16];
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] sel,
                       input logic [15:0] d);
    in_valid = v;
    in_sel   = sel;
    in_data  = d;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_sel    = 3'd0;
    out_ready = 8'h00;
`ifdef DMUX8WAY16_BCAST_EN
    in_bcast  = 1'b0;
`endif

    // Reset state
    #1;
    check("rst_out_valid", out_valid, 8'h00);
    check("rst_out_data", out_data, 128'h0);
    check("rst_accept_cnt", accept_cnt, 16'h0000);
    check("rst_in_ready", in_ready, 1'b1);
    repeat (2) tick();
    rst_n = 1'b1;

    // Routing sweep: each channel shows its word for exactly one cycle
    out_ready = 8'hFF;
    drive(1'b1, 3'd0, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("sweep_valid_%0d", i), out_valid, 8'h01 << i);
      check($sformatf("sweep_data_%0d", i), lane(i), 16'(i));
      if (i < 7) drive(1'b1, 3'(i + 1), 16'(i + 1));
      else       drive(1'b0, 3'd0, 16'h0000);
    end
    tick();
    check("sweep_drained", out_valid, 8'h00);
    check("sweep_accept_cnt", accept_cnt, 16'd8);

    // Full and backpressure on channel 3
    out_ready = 8'hF7;
    drive(1'b1, 3'd3, 16'hAAAA);
    #1 check("full_rdy_1", in_ready, 1'b1);
    tick();
    drive(1'b1, 3'd3, 16'hBBBB);
    #1 check("full_rdy_2", in_ready, 1'b1);
    tick();
    drive(1'b1, 3'd3, 16'hCCCC);
    #1 check("full_rdy_3", in_ready, 1'b0);
    check("full_head_a", lane(3), 16'hAAAA);
    tick();
    check("full_still_blocked", in_ready, 1'b0);
    out_ready = 8'hFF;
    // Full channel popping this cycle still refuses the push
    #1 check("full_no_bypass", in_ready, 1'b0);
    tick();
    check("full_head_b", lane(3), 16'hBBBB);
    check("full_rdy_after_pop", in_ready, 1'b1);
    tick();
    check("full_head_c", lane(3), 16'hCCCC);
    check("full_valid_c", out_valid, 8'h08);
    drive(1'b0, 3'd0, 16'h0000);
    tick();
    check("full_drained_valid", out_valid[3], 1'b0);
    check("full_drained_data", lane(3), 16'h0000);
    check("full_accept_cnt", accept_cnt, 16'd11);

    // Simultaneous push and pop on channel 5
    out_ready = 8'hDF;
    drive(1'b1, 3'd5, 16'h5551);
    tick();
    check("pp_head_1", lane(5), 16'h5551);
    out_ready = 8'hFF;
    drive(1'b1, 3'd5, 16'h5552);
    #1 check("pp_rdy", in_ready, 1'b1);
    tick();
    check("pp_valid", out_valid[5], 1'b1);
    check("pp_head_2", lane(5), 16'h5552);
    drive(1'b0, 3'd0, 16'h0000);
    tick();
    // Count stayed at 1, so a single pop empties the channel
    check("pp_empty_after_one_pop", out_valid, 8'h00);
    check("pp_accept_cnt", accept_cnt, 16'd13);

    // Reset mid-stream with channels 0 and 7 full
    out_ready = 8'h00;
    drive(1'b1, 3'd0, 16'h0A01); tick();
    drive(1'b1, 3'd0, 16'h0A02); tick();
    drive(1'b1, 3'd7, 16'h7A01); tick();
    drive(1'b1, 3'd7, 16'h7A02); tick();
    drive(1'b0, 3'd0, 16'h0000);
    #1;
    check("mid_valid_before", out_valid, 8'h81);
    check("mid_full_ch0", in_ready, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 8'h00);
    check("mid_rst_data", out_data, 128'h0);
    check("mid_rst_accept", accept_cnt, 16'h0000);
    check("mid_rst_rdy", in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_after_release", out_valid, 8'h00);
    // First push right after release
    drive(1'b1, 3'd1, 16'h0101);
    tick();
    check("post_rst_valid", out_valid, 8'h02);
    check("post_rst_data", lane(1), 16'h0101);
    check("post_rst_accept", accept_cnt, 16'd1);
    drive(1'b0, 3'd0, 16'h0000);
    out_ready = 8'hFF;
    tick();

    // Counter wrap: 65536 pushes starting from a fresh reset
    rst_n = 1'b0;
    #1 check("wrap_rst_accept", accept_cnt, 16'h0000);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      if (i == 65535) check("wrap_at_ffff", accept_cnt, 16'hFFFF);
      drive(1'b1, 3'(i % 8), 16'(i));
      if (i == 1000) #1 check("wrap_rdy_mid", in_ready, 1'b1);
      tick();
      if (i == 1000) check("wrap_lane_mid", lane(0), 16'(1000));
    end
    drive(1'b0, 3'd0, 16'h0000);
    check("wrap_accept_zero", accept_cnt, 16'h0000);
    tick();
    check("wrap_drained", out_valid, 8'h00);

`ifdef DMUX8WAY16_BCAST_EN
    // Broadcast: all eight lanes receive the word
    out_ready = 8'h00;
    in_bcast  = 1'b1;
    drive(1'b1, 3'd0, 16'h1234);
    #1 check("bc_rdy", in_ready, 1'b1);
    tick();
    check("bc_valid", out_valid, 8'hFF);
    for (int k = 0; k < 8; k++) check($sformatf("bc_lane_%0d", k), lane(k), 16'h1234);
    in_bcast = 1'b0;
    drive(1'b1, 3'd2, 16'h2222);
    tick();
    in_bcast = 1'b1;
    drive(1'b1, 3'd0, 16'h5678);
    #1 check("bc_blocked_ch2_full", in_ready, 1'b0);
    in_bcast = 1'b0;
    drive(1'b0, 3'd0, 16'h0000);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
